fft_buf_stream_reader: RTL and testbench

//  Read-side controller for the two-port FFT result LSRAM buffer (2048 x 64). The FFT core fills the buffer through
//  the write port. This block then unloads one full frame through the read port. It issues read addresses, absorbs
//  the fixed RAM read latency with a credit-controlled skid FIFO, and streams words out on a valid/ready interface

---
 rtl/fft_buf_stream_reader_if.sv | 24 ++
 rtl/fft_buf_stream_reader.sv | 154 +++++++++++++++
 tb/tb_fft_buf_stream_reader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_buf_stream_reader_if.sv
// Bus bundle for fft_buf_stream_reader: LSRAM read port plus the output stream.
// master = reader; slave = RAM / downstream side.
interface fft_buf_stream_reader_if #(
   parameter int AWIDTH = 11,
   parameter int DWIDTH = 64
);
   logic [AWIDTH-1:0] ram_raddr;
   logic [DWIDTH-1:0] ram_do;
   logic [DWIDTH-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_sof;
   logic              out_eof;

   modport master (
      output ram_raddr, out_data, out_valid, out_sof, out_eof,
      input  ram_do, out_ready
   );

   modport slave (
      input  ram_raddr, out_data, out_valid, out_sof, out_eof,
      output ram_do, out_ready
   );
endinterface

// File: rtl/fft_buf_stream_reader.sv
// Unloads one N-word frame from the FFT result LSRAM into a valid/ready stream with sof/eof markers.
// Optional FFT_BUF_BITREV_EN: issue addresses in bit-reversed order (DIT results out in natural order).
module fft_buf_stream_reader #(
   parameter int AWIDTH     = 11,
   parameter int DWIDTH     = 64,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    nGrst,
   input  logic                    start,
   fft_buf_stream_reader_if.master bus,
   output logic                    busy,
   output logic                    done
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
   localparam logic [AWIDTH:0] LAST_IDX = {1'b0, {AWIDTH{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t                state;
   logic [AWIDTH:0]       issue_cnt;
   logic [AWIDTH-1:0]     raddr;
   logic [IW-1:0]         in_flight;
   logic [RD_LAT-1:0]     tag_v;
   logic [RD_LAT-1:0]     tag_sof;
   logic [RD_LAT-1:0]     tag_eof;
   logic [DWIDTH-1:0]     fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_sof;
   logic [FIFO_DEPTH-1:0] fifo_eof;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         fifo_count;
   logic [31:0]           credit_used;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  empty;
   logic                  eof_pop;

   function automatic logic [AWIDTH-1:0] addr_map(input logic [AWIDTH-1:0] idx);
      logic [AWIDTH-1:0] a;
`ifdef FFT_BUF_BITREV_EN
      for (int unsigned b = 0; b < AWIDTH; b++) a[b] = idx[AWIDTH-1-b];
`else
      a = idx;
`endif
      return a;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // ram_raddr is the RAM's address-register stage, so a word pushed RD_LAT edges after issue
   // holds exactly one credit per pipeline stage; credits are counted from registered state only.
   always_comb begin
      credit_used = 32'(in_flight) + 32'(fifo_count);
      issue       = (state == S_READ) && (credit_used < 32'(FIFO_DEPTH));
      push        = tag_v[RD_LAT-1];
      empty       = (fifo_count == '0);
      pop         = !empty && bus.out_ready;
      eof_pop     = pop && fifo_eof[rd_ptr];
   end

   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) begin
         state     <= S_IDLE;
         issue_cnt <= '0;
         raddr     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_READ;
                  issue_cnt <= '0;
                  busy      <= 1'b1;
               end
            end
            S_READ: begin
               if (issue) begin
                  raddr     <= addr_map(issue_cnt[AWIDTH-1:0]);
                  issue_cnt <= issue_cnt + (AWIDTH+1)'(1);
                  if (issue_cnt == LAST_IDX) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // The eof word is the last one issued, so its pop leaves the FIFO and pipe empty.
               if (eof_pop && (in_flight == '0)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) begin
         tag_v     <= '0;
         tag_sof   <= '0;
         tag_eof   <= '0;
         in_flight <= '0;
      end else begin
         tag_v[0]   <= issue;
         tag_sof[0] <= issue && (issue_cnt == '0);
         tag_eof[0] <= issue && (issue_cnt == LAST_IDX);
         for (int unsigned k = 1; k < RD_LAT; k++) begin
            tag_v[k]   <= tag_v[k-1];
            tag_sof[k] <= tag_sof[k-1];
            tag_eof[k] <= tag_eof[k-1];
         end
         if (issue && !push)      in_flight <= in_flight + IW'(1);
         else if (!issue && push) in_flight <= in_flight - IW'(1);
      end
   end

   always_ff @(posedge clk or negedge nGrst) begin
      if (!nGrst) begin
         for (int unsigned k = 0; k < FIFO_DEPTH; k++) fifo_data[k] <= '0;
         fifo_sof   <= '0;
         fifo_eof   <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= bus.ram_do;
            fifo_sof[wr_ptr]  <= tag_sof[RD_LAT-1];
            fifo_eof[wr_ptr]  <= tag_eof[RD_LAT-1];
            wr_ptr            <= next_ptr(wr_ptr);
         end
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      fifo_count <= fifo_count + CW'(1);
         else if (!push && pop) fifo_count <= fifo_count - CW'(1);
      end
   end

   overflow_check: assert property (@(posedge clk) disable iff (!nGrst)
      !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

   assign bus.ram_raddr = raddr;
   assign bus.out_valid = !empty;
   assign bus.out_data  = fifo_data[rd_ptr];
   assign bus.out_sof   = !empty && fifo_sof[rd_ptr];
   assign bus.out_eof   = !empty && fifo_eof[rd_ptr];
endmodule

// File: tb/tb_fft_buf_stream_reader.sv
// Bench for fft_buf_stream_reader: RAM model with random contents, frame-level reference of the stream.
// Follows FFT_BUF_BITREV_EN for the expected read order.
module tb_fft_buf_stream_reader;
   localparam int AWIDTH     = 11;
   localparam int DWIDTH     = 64;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int N          = 1 << AWIDTH;

   logic clk   = 1'b0;
   logic nGrst = 1'b0;
   logic start = 1'b0;
   logic busy;
   logic done;

   fft_buf_stream_reader_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

   fft_buf_stream_reader #(
      .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .nGrst(nGrst), .start(start), .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // ram_raddr is the RAM address register; one more output register gives RD_LAT = 2.
   logic [DWIDTH-1:0] mem [N];
   always @(posedge clk) bus.ram_do <= mem[bus.ram_raddr];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_edge = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int stall_err = 0;
   int rdy_mode = 1;
   logic prev_hold = 1'b0;
   logic [DWIDTH+1:0] prev_word;
   logic [DWIDTH+1:0] got_word [$];
   int got_cyc [$];

   function automatic int unsigned order_of(input int unsigned i);
`ifdef FFT_BUF_BITREV_EN
      int unsigned r = 0;
      for (int unsigned b = 0; b < AWIDTH; b++)
         if (((i >> b) & 1) != 0) r = r + (1 << (AWIDTH - 1 - b));
      return r;
`else
      return i;
`endif
   endfunction

   function automatic logic [DWIDTH+1:0] exp_word(input int unsigned i);
      return {(i == 0), (i == N - 1), mem[order_of(i)]};
   endfunction

   task automatic step();
      @(negedge clk);
      if (nGrst) begin
         if (prev_hold && (!bus.out_valid || {bus.out_sof, bus.out_eof, bus.out_data} !== prev_word))
            stall_err++;
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_word = {bus.out_sof, bus.out_eof, bus.out_data};
         if (bus.out_valid && bus.out_ready) begin
            got_word.push_back({bus.out_sof, bus.out_eof, bus.out_data});
            got_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else begin
         prev_hold = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
      case (rdy_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'b1;
         default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic clear_capture();
      got_word.delete();
      got_cyc.delete();
      done_cnt  = 0;
      done_cyc  = -1;
      stall_err = 0;
      prev_hold = 1'b0;
   endtask

   task automatic preload(input bit identity);
      for (int a = 0; a < N; a++) mem[a] = identity ? DWIDTH'(a) : {$urandom, $urandom};
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      start_edge = cyc;
   endtask

   task automatic run_frame(input int budget, input int stop_beats, output bit timed_out);
      int n = 0;
      while (done_cnt == 0 && got_word.size() < stop_beats && n < budget) begin
         step();
         n++;
      end
      timed_out = (done_cnt == 0 && got_word.size() < stop_beats);
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b0;
      nGrst = 1'b0;
      #12;
      checks++;
      if ({bus.ram_raddr, bus.out_data, bus.out_valid, bus.out_sof, bus.out_eof, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got raddr=%0d data=%h v=%b sof=%b eof=%b busy=%b done=%b, want all 0",
                  bus.ram_raddr, bus.out_data, bus.out_valid, bus.out_sof, bus.out_eof, busy, done);
      end
      @(posedge clk);
      #1;
      nGrst = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", busy, bus.out_valid);
      end
   endtask

   task automatic test_full_rate();
      bit to;
      int errs = 0;
      int bad = 0;
      int last;
      preload(1'b1);
      clear_capture();
      rdy_mode = 1;
      bus.out_ready = 1'b1;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL full_busy: busy=%b want 1", busy);
      end
      run_frame(N + 64, N + 1, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL full_timeout: no done within budget, beats=%0d", got_word.size());
      end
      checks++;
      if (got_word.size() !== N) begin
         failures++;
         $display("FAIL full_count: got %0d beats want %0d", got_word.size(), N);
      end
      foreach (got_word[i]) if (got_word[i] !== exp_word(i)) begin
         if (errs == 0) bad = i;
         errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL full_data: %0d bad beats, beat %0d got %h want %h", errs, bad, got_word[bad], exp_word(bad));
      end
      last = got_cyc.size() - 1;
      if (last >= 0) begin
         checks++;
         if (got_cyc[0] - start_edge !== RD_LAT + 1) begin
            failures++;
            $display("FAIL full_latency: got %0d clocks want %0d", got_cyc[0] - start_edge, RD_LAT + 1);
         end
         checks++;
         if (got_cyc[last] - got_cyc[0] !== N - 1) begin
            failures++;
            $display("FAIL full_gapless: span %0d clocks want %0d", got_cyc[last] - got_cyc[0], N - 1);
         end
         checks++;
         if (done_cyc !== got_cyc[last] + 1) begin
            failures++;
            $display("FAIL full_done_time: done at %0d want %0d", done_cyc, got_cyc[last] + 1);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL full_busy_end: busy=%b want 0", busy);
      end
      repeat (6) step();
      checks++;
      if (done_cnt !== 1) begin
         failures++;
         $display("FAIL full_done_pulses: got %0d want 1", done_cnt);
      end
   endtask

   task automatic test_backpressure_random();
      bit to;
      int errs = 0;
      int bad = 0;
      preload(1'b0);
      clear_capture();
      rdy_mode = 2;
      pulse_start();
      run_frame(10 * N, N + 1, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL rand_timeout: no done within budget, beats=%0d", got_word.size());
      end
      checks++;
      if (got_word.size() !== N) begin
         failures++;
         $display("FAIL rand_count: got %0d beats want %0d", got_word.size(), N);
      end
      foreach (got_word[i]) if (got_word[i] !== exp_word(i)) begin
         if (errs == 0) bad = i;
         errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL rand_data: %0d bad beats, beat %0d got %h want %h", errs, bad, got_word[bad], exp_word(bad));
      end
      checks++;
      if (stall_err !== 0) begin
         failures++;
         $display("FAIL rand_stall_stable: %0d unstable stalled cycles, want 0", stall_err);
      end
      rdy_mode = 1;
      repeat (4) step();
      checks++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rand_done: done pulses=%0d busy=%b, want 1 and 0", done_cnt, busy);
      end
   endtask

   task automatic test_start_while_busy();
      bit to;
      int errs = 0;
      int bad = 0;
      preload(1'b0);
      clear_capture();
      rdy_mode = 1;
      bus.out_ready = 1'b1;
      pulse_start();
      run_frame(200, 100, to);
      checks++;
      if (to || busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_reach100: beats=%0d busy=%b, want 100 beats and busy", got_word.size(), busy);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      run_frame(N + 64, N + 1, to);
      repeat (8) step();
      checks++;
      if (got_word.size() !== N) begin
         failures++;
         $display("FAIL busy_count: got %0d beats want %0d", got_word.size(), N);
      end
      foreach (got_word[i]) if (got_word[i] !== exp_word(i)) begin
         if (errs == 0) bad = i;
         errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL busy_data: %0d bad beats, beat %0d got %h want %h", errs, bad, got_word[bad], exp_word(bad));
      end
      checks++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_done: done pulses=%0d busy=%b, want 1 and 0", done_cnt, busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit to;
      int errs = 0;
      int bad = 0;
      preload(1'b0);
      clear_capture();
      rdy_mode = 1;
      bus.out_ready = 1'b1;
      pulse_start();
      run_frame(N, 500, to);
      nGrst = 1'b0;
      #1;
      checks++;
      if ({bus.ram_raddr, bus.out_data, bus.out_valid, bus.out_sof, bus.out_eof, busy, done} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs: got raddr=%0d data=%h v=%b sof=%b eof=%b busy=%b done=%b, want all 0",
                  bus.ram_raddr, bus.out_data, bus.out_valid, bus.out_sof, bus.out_eof, busy, done);
      end
      repeat (3) step();
      nGrst = 1'b1;
      repeat (6) step();
      checks++;
      if (done_cnt !== 0 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_abandon: done pulses=%0d busy=%b valid=%b, want 0 0 0", done_cnt, busy, bus.out_valid);
      end
      clear_capture();
      pulse_start();
      run_frame(N + 64, N + 1, to);
      checks++;
      if (got_word.size() == 0 || got_word[0] !== exp_word(0)) begin
         failures++;
         $display("FAIL midreset_restart: first beat %h want %h", got_word.size() ? got_word[0] : '0, exp_word(0));
      end
      foreach (got_word[i]) if (got_word[i] !== exp_word(i)) begin
         if (errs == 0) bad = i;
         errs++;
      end
      checks++;
      if (to || errs != 0 || got_word.size() !== N) begin
         failures++;
         $display("FAIL midreset_frame: beats=%0d bad=%0d timeout=%0b, want %0d 0 0", got_word.size(), errs, to, N);
      end
   endtask

   task automatic test_stall_from_start();
      bit to;
      int errs = 0;
      int last;
      logic [DWIDTH+1:0] head;
      preload(1'b0);
      clear_capture();
      rdy_mode = 0;
      bus.out_ready = 1'b0;
      pulse_start();
      repeat (20) step();
      head = exp_word(0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== head[DWIDTH-1:0] || bus.out_sof !== 1'b1) begin
         failures++;
         $display("FAIL stall_head: v=%b sof=%b data=%h, want 1 1 %h", bus.out_valid, bus.out_sof, bus.out_data,
                  head[DWIDTH-1:0]);
      end
      checks++;
      if (32'(bus.ram_raddr) !== order_of(FIFO_DEPTH - 1)) begin
         failures++;
         $display("FAIL stall_issue_stop: raddr=%0d want %0d", bus.ram_raddr, order_of(FIFO_DEPTH - 1));
      end
      checks++;
      if (got_word.size() !== 0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL stall_no_beats: beats=%0d busy=%b, want 0 and 1", got_word.size(), busy);
      end
      rdy_mode = 1;
      bus.out_ready = 1'b1;
      run_frame(N + 64, N + 1, to);
      foreach (got_word[i]) if (got_word[i] !== exp_word(i)) errs++;
      checks++;
      if (to || errs != 0 || got_word.size() !== N) begin
         failures++;
         $display("FAIL stall_frame: beats=%0d bad=%0d timeout=%0b, want %0d 0 0", got_word.size(), errs, to, N);
      end
      last = got_cyc.size() - 1;
      checks++;
      if (last < 0 || got_cyc[last] - got_cyc[0] !== N - 1) begin
         failures++;
         $display("FAIL stall_resume_rate: span %0d clocks want %0d", last < 0 ? -1 : got_cyc[last] - got_cyc[0], N - 1);
      end
      checks++;
      if (stall_err !== 0 || done_cnt !== 1) begin
         failures++;
         $display("FAIL stall_misc: unstable=%0d done pulses=%0d, want 0 1", stall_err, done_cnt);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_rate();
      test_backpressure_random();
      test_start_while_busy();
      test_reset_mid_frame();
      test_stall_from_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
